updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised up/down counter; successor to the fixed 4-bit down counter, generalised to WIDTH bits.
- Adds a programmable modulus, parallel load, count enable, direction select, and a one-shot (stop-at-terminal) mode.
- Used as the general-purpose counter/timer primitive for timers, dividers and sequencers in the internship design set.
- With WIDTH=4, max_val=15, up_dn=0, en=1 it behaves exactly like the legacy 4-bit down counter.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- RST_VAL, 0, value loaded into count on reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  count enable; count advances only when high.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled every cycle.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value for load.
- max_val  input  WIDTH  terminal value of the upper bound; count range is 0..max_val. Treat as quasi-static.
- one_shot  input  1  1 = stop at terminal value and assert done; 0 = wrap around.
- count  output  WIDTH  registered counter value.
- wrap  output  1  registered one-cycle pulse on each wrap event.
- done  output  1  registered sticky flag; one-shot terminal reached.

Behaviour:
- All state updates occur on the rising clk edge. Outputs are registered, with no combinational paths from inputs to outputs.
- Reset (rst=1 at an edge): count=RST_VAL, wrap=0, done=0. Reset overrides every other input and may be applied mid-count.
- Priority per edge: rst > load > (en and not done) > hold.
- Load:
  - count = min(load_val, max_val); done=0; wrap=0.
  - The en and up_dn inputs are ignored that cycle.
- Counting, down (up_dn=0, en=1, done=0):
  - count>max_val: count=max_val (resync after a max_val change), with no wrap pulse.
  - 0<count<=max_val: count=count-1.
  - count==0 and one_shot=0: count=max_val, wrap=1.
  - count==0 and one_shot=1: count holds at 0, done=1, wrap=1.
- Counting, up (up_dn=1, en=1, done=0):
  - count<max_val: count=count+1.
  - count>=max_val and one_shot=0: count=0, wrap=1.
  - count>=max_val and one_shot=1: count holds, done=1, wrap=1.
- wrap:
  - High for exactly the one cycle following the edge at which the boundary event occurred.
  - Otherwise 0, including while holding with done=1.
- done:
  - Once set, counting is frozen regardless of en or up_dn.
  - Cleared only by rst or load.
  - Changing one_shot to 0 while done=1 does not clear done.
- en=0: count, done hold; wrap=0.
- Direction change mid-count takes effect on the next enabled edge, with no extra latency and no skipped value.
- max_val=0: count stays 0. With one_shot=0, every enabled cycle produces wrap=1. With one_shot=1, done sets on the first enabled cycle.
- Arithmetic is modulo 2^WIDTH internally, but the bounds above ensure it never relies on natural overflow. With max_val=2^WIDTH-1 the up/down wrap coincides with natural wrap.

Test Plan:
- Legacy equivalence: WIDTH=4, RST_VAL=0, max_val=15, up_dn=0, en=1, one_shot=0; rst high 1 cycle then low → count sequence 0,15,14,…,1,0,15. wrap=1 in the cycle count shows 15 after 0. Re-assert rst mid-count → count=0 on the next edge.
- Modulus up count: max_val=9, up_dn=1 → 0..9,0,… with a wrap pulse exactly once per 10 cycles. Drop en for 3 cycles at count=5 → count holds at 5 and wrap stays 0.
- One-shot down: load=1 with load_val=3, one_shot=1, up_dn=0 → count 3,2,1,0 then holds at 0. done=1 from the cycle after 0 was reached, with a single wrap pulse. Then load_val=2 → done=0 and the count restarts at 2.
- Load clamp and priority: max_val=9, load_val=14 with load=1 and en=1 on the same edge → count=9. Asserting rst and load together → count=RST_VAL.
- Direction switch and resync: count=7, toggle up_dn each cycle → 8,7,8,7. Set max_val=4 while count=7, up_dn=0 → next count=4, no wrap pulse.
- Degenerate modulus: max_val=0, one_shot=0, en=1 → count stays 0 and wrap=1 every cycle. With one_shot=1 → done=1 after the first enabled edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// General-purpose WIDTH-bit up/down counter with a programmable upper bound,
// synchronous parallel load, count enable and an optional one-shot mode that
// freezes the count at the terminal value and raises a sticky done flag.
// With WIDTH=4, max_val=15, up_dn=0 and en=1 it reproduces the legacy 4-bit
// down counter.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (count=RST_VAL, flags cleared)
//   en        in   count enable
//   up_dn     in   direction: 1 = up, 0 = down
//   load      in   synchronous load strobe (beats en/up_dn)
//   load_val  in   [WIDTH-1:0] load value, clamped to max_val
//   max_val   in   [WIDTH-1:0] upper bound of the count range 0..max_val
//   one_shot  in   1 = stop at terminal and set done, 0 = wrap around
//   count     out  [WIDTH-1:0] registered count
//   wrap      out  registered one-cycle pulse on each boundary event
//   done      out  registered sticky flag, one-shot terminal reached
// -----------------------------------------------------------------------------
module updown_counter_param #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg,  wrap_next;
    logic             done_reg,  done_next;

    // Boundary comparisons shared by both directions.
    logic at_zero;
    logic above_max;
    logic at_or_above_max;

    assign at_zero         = (count_reg == '0);
    assign above_max       = (count_reg > max_val);
    assign at_or_above_max = (count_reg >= max_val);

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        done_next  = done_reg;

        if (load) begin
            count_next = (load_val > max_val) ? max_val : load_val;
            done_next  = 1'b0;
        end else if (en && !done_reg) begin
            if (up_dn) begin
                if (!at_or_above_max) begin
                    count_next = count_reg + 1'b1;
                end else if (one_shot) begin
                    // Terminal reached: freeze where we are.
                    wrap_next = 1'b1;
                    done_next = 1'b1;
                end else begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (at_zero) begin
                    wrap_next = 1'b1;
                    if (one_shot) begin
                        done_next = 1'b1;
                    end else begin
                        count_next = max_val;
                    end
                end else if (above_max) begin
                    // max_val was lowered under us: snap back into range
                    // silently rather than counting down from the old value.
                    count_next = max_val;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= RST_VEC;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            done_reg  <= done_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] max_val;
    logic       one_shot;
    logic [3:0] count;
    logic       wrap;
    logic       done;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .RST_VAL(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .one_shot (one_shot),
        .count    (count),
        .wrap     (wrap),
        .done     (done)
    );

    typedef struct {
        logic [3:0]  c;
        logic        w;
        logic        d;
        logic [63:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Push the expected post-edge outputs for the inputs currently driven,
    // then advance to the next negedge where the next inputs are applied.
    task automatic tick(input logic [3:0] c, input logic w, input logic d,
                        input logic [63:0] tag);
        exp_t e;
        e.c = c; e.w = w; e.d = d; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every edge the DUT presents fresh registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if (count !== e.c || wrap !== e.w || done !== e.d) begin
                    mismatched++;
                    $display("FAIL %0s #%0d: got count=%0d wrap=%0b done=%0b, expected count=%0d wrap=%0b done=%0b",
                             e.tag, compared, count, wrap, done, e.c, e.w, e.d);
                end else begin
                    $display("txn %0d %0s: count=%0d wrap=%0b done=%0b ok",
                             compared, e.tag, count, wrap, done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; up_dn = 1'b0; load = 1'b0;
        load_val = 4'd0; max_val = 4'd15; one_shot = 1'b0;
        @(negedge clk);

        // Legacy equivalence: 0,15,14,...,0,15
        tick(4'd0, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        tick(4'd15, 1'b1, 1'b0, "legacy");
        for (int v = 14; v >= 0; v--) tick(4'(v), 1'b0, 1'b0, "legacy");
        tick(4'd15, 1'b1, 1'b0, "legwrap");
        tick(4'd14, 1'b0, 1'b0, "legacy");
        rst = 1'b1;
        tick(4'd0, 1'b0, 1'b0, "midrst");

        // Modulus-10 up count with an enable gap
        rst = 1'b0; max_val = 4'd9; up_dn = 1'b1;
        for (int v = 1; v <= 9; v++) tick(4'(v), 1'b0, 1'b0, "mod10");
        tick(4'd0, 1'b1, 1'b0, "mod10wr");
        for (int v = 1; v <= 5; v++) tick(4'(v), 1'b0, 1'b0, "mod10");
        en = 1'b0;
        for (int k = 0; k < 3; k++) tick(4'd5, 1'b0, 1'b0, "enlow");
        en = 1'b1;
        for (int v = 6; v <= 9; v++) tick(4'(v), 1'b0, 1'b0, "mod10");
        tick(4'd0, 1'b1, 1'b0, "mod10wr");

        // One-shot down from a load of 3
        load = 1'b1; load_val = 4'd3; one_shot = 1'b1; up_dn = 1'b0;
        tick(4'd3, 1'b0, 1'b0, "osload");
        load = 1'b0;
        tick(4'd2, 1'b0, 1'b0, "osdown");
        tick(4'd1, 1'b0, 1'b0, "osdown");
        tick(4'd0, 1'b0, 1'b0, "osdown");
        tick(4'd0, 1'b1, 1'b1, "osterm");
        tick(4'd0, 1'b0, 1'b1, "oshold");
        tick(4'd0, 1'b0, 1'b1, "oshold");
        up_dn = 1'b1;
        tick(4'd0, 1'b0, 1'b1, "osfrzup");
        one_shot = 1'b0;
        tick(4'd0, 1'b0, 1'b1, "osstick");
        load = 1'b1; load_val = 4'd2; one_shot = 1'b1;
        tick(4'd2, 1'b0, 1'b0, "osrelod");
        load = 1'b0; up_dn = 1'b0;
        tick(4'd1, 1'b0, 1'b0, "osdown");

        // One-shot up to max_val
        load = 1'b1; load_val = 4'd8; up_dn = 1'b1;
        tick(4'd8, 1'b0, 1'b0, "osupld");
        load = 1'b0;
        tick(4'd9, 1'b0, 1'b0, "osup");
        tick(4'd9, 1'b1, 1'b1, "osupend");
        tick(4'd9, 1'b0, 1'b1, "osuphld");

        // Load clamp, and reset beating load
        one_shot = 1'b0; load = 1'b1; load_val = 4'd14; en = 1'b1;
        tick(4'd9, 1'b0, 1'b0, "clamp");
        rst = 1'b1; load_val = 4'd5;
        tick(4'd0, 1'b0, 1'b0, "rstload");

        // Direction toggling and resync after max_val shrinks
        rst = 1'b0; load = 1'b1; load_val = 4'd7;
        tick(4'd7, 1'b0, 1'b0, "ld7");
        load = 1'b0;
        up_dn = 1'b1; tick(4'd8, 1'b0, 1'b0, "dirup");
        up_dn = 1'b0; tick(4'd7, 1'b0, 1'b0, "dirdn");
        up_dn = 1'b1; tick(4'd8, 1'b0, 1'b0, "dirup");
        up_dn = 1'b0; tick(4'd7, 1'b0, 1'b0, "dirdn");
        max_val = 4'd4;
        tick(4'd4, 1'b0, 1'b0, "resync");
        tick(4'd3, 1'b0, 1'b0, "resyncd");
        max_val = 4'd9; load = 1'b1; load_val = 4'd8;
        tick(4'd8, 1'b0, 1'b0, "ld8");
        load = 1'b0; max_val = 4'd4; up_dn = 1'b1;
        tick(4'd0, 1'b1, 1'b0, "upover");

        // Full range up: bound coincides with natural wrap
        max_val = 4'd15; load = 1'b1; load_val = 4'd14;
        tick(4'd14, 1'b0, 1'b0, "ld14");
        load = 1'b0;
        tick(4'd15, 1'b0, 1'b0, "fullup");
        tick(4'd0, 1'b1, 1'b0, "fullwr");

        // Degenerate modulus
        max_val = 4'd0; load = 1'b1; load_val = 4'd6; up_dn = 1'b0;
        tick(4'd0, 1'b0, 1'b0, "m0load");
        load = 1'b0;
        for (int k = 0; k < 3; k++) tick(4'd0, 1'b1, 1'b0, "m0wrap");
        up_dn = 1'b1;
        tick(4'd0, 1'b1, 1'b0, "m0wrapu");
        one_shot = 1'b1;
        tick(4'd0, 1'b1, 1'b1, "m0done");
        tick(4'd0, 1'b0, 1'b1, "m0hold");

        // Let the monitor drain the last expectation.
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
